// File: rtl/cam_stream_pkg.sv
// Shared definitions for the CAM kernel p0 stream: op encoding, header bit positions, header layout.
// The CAM kernel's input decoder imports this package too, so both ends agree on the header format.
package cam_stream_pkg;

  typedef enum logic [1:0] {
    CAM_OP_LOAD   = 2'b01,
    CAM_OP_SEARCH = 2'b10
  } cam_op_e;

  localparam int COUNT_LSB = 512;
  localparam int LAST_BIT  = 517;
  localparam int OP_LSB    = 518;
  localparam int CNT_W     = 5;
  localparam int HDR_W     = 8;

  // The header occupies the top 8 bits of the word: {op, last, count}
  typedef struct packed {
    cam_op_e          op;
    logic             last;
    logic [CNT_W-1:0] count;
  } hdr_t;

  function automatic cam_op_e op_from_user(input logic user);
    return user ? CAM_OP_SEARCH : CAM_OP_LOAD;
  endfunction

endpackage

// File: rtl/cam_stream_out_reg.sv
// Single-entry AXI-Stream output register holding one packed word; a new word can load while the old one drains.
// Data and valid are held while the consumer stalls; free_o tells the packer when a load is allowed.
module cam_stream_out_reg #(
  parameter int W = 520
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] dat_i,
  input  logic         rdy_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  output logic         free_o
);

  logic         vld_q;
  logic [W-1:0] dat_q;

  assign free_o = !vld_q || rdy_i;
  assign vld_o  = vld_q;
  assign dat_o  = dat_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (load_i) begin
      vld_q <= 1'b1;
      dat_q <= dat_i;
    end else if (rdy_i) begin
      vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/cam_stream_packer.sv
// Packs 32-bit LOAD/SEARCH vertex IDs into 520-bit CAM words; CAM_PACK_TIMEOUT_EN adds an idle flush of partial packs.
// Word valid one cycle after its last beat; s_TREADY drops while a completed pack waits for the output register.
module cam_stream_packer
  import cam_stream_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 520,
  parameter int ELEM_WIDTH     = 32,
  parameter int LANES          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [ELEM_WIDTH-1:0]   s_TDATA,
  input  logic                    s_TVALID,
  output logic                    s_TREADY,
  input  logic                    s_TLAST,
  input  logic                    s_TUSER,
  output logic [C_DATA_WIDTH-1:0] p0_TDATA,
  output logic                    p0_TVALID,
  input  logic                    p0_TREADY
);

  localparam int IDX_W = $clog2(LANES);

  if (C_DATA_WIDTH != LANES * ELEM_WIDTH + HDR_W) begin : g_bad_width
    $error("cam_stream_packer: C_DATA_WIDTH must equal LANES*ELEM_WIDTH+8");
  end
  if (LANES >= (1 << CNT_W) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cam_stream_packer: LANES must fit the count field and TIMEOUT_CYCLES must be positive");
  end

  logic [ELEM_WIDTH-1:0] lanes_q [LANES];
  logic [ELEM_WIDTH-1:0] lanes_d [LANES];
  logic [ELEM_WIDTH-1:0] lanes_nxt [LANES];
  logic [ELEM_WIDTH-1:0] word_lanes [LANES];
  logic [CNT_W-1:0]      count_q, count_d, cnt_nxt;
  cam_op_e               op_q, op_d, beat_op;
  logic                  last_q, last_d, pending_q, pending_d;
  logic                  mismatch, accept, out_free, out_load;
  hdr_t                  out_hdr;
  logic [C_DATA_WIDTH-1:0] out_word;

`ifdef CAM_PACK_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  assign beat_op  = op_from_user(s_TUSER);
  assign mismatch = (count_q != '0) && (beat_op != op_q);
  // A mismatched beat needs the output register for the pack it closes
  assign s_TREADY = ap_rst_n && !pending_q && !(s_TVALID && mismatch && !out_free);
  assign accept   = s_TVALID && s_TREADY;

  always_comb begin
    lanes_nxt = lanes_q;
    lanes_nxt[count_q[IDX_W-1:0]] = s_TDATA;
    cnt_nxt    = count_q + CNT_W'(1);
    lanes_d    = lanes_q;
    count_d    = count_q;
    op_d       = op_q;
    last_d     = last_q;
    pending_d  = pending_q;
    word_lanes = lanes_q;
    out_hdr    = '{op: op_q, last: last_q, count: count_q};
    out_load   = 1'b0;
`ifdef CAM_PACK_TIMEOUT_EN
    idle_d     = idle_q;
`endif
    if (pending_q) begin
      if (out_free) begin
        out_load  = 1'b1;
        pending_d = 1'b0;
        count_d   = '0;
        lanes_d   = '{default: '0};
      end
    end else if (accept) begin
`ifdef CAM_PACK_TIMEOUT_EN
      idle_d = '0;
`endif
      if (mismatch) begin
        out_load     = 1'b1;
        out_hdr.last = 1'b0;
        lanes_d      = '{default: '0};
        lanes_d[0]   = s_TDATA;
        count_d      = CNT_W'(1);
        op_d         = beat_op;
        last_d       = s_TLAST;
        pending_d    = s_TLAST;
      end else if (cnt_nxt == CNT_W'(LANES) || s_TLAST) begin
        if (out_free) begin
          out_load   = 1'b1;
          word_lanes = lanes_nxt;
          out_hdr    = '{op: beat_op, last: s_TLAST, count: cnt_nxt};
          count_d    = '0;
          lanes_d    = '{default: '0};
        end else begin
          lanes_d   = lanes_nxt;
          count_d   = cnt_nxt;
          op_d      = beat_op;
          last_d    = s_TLAST;
          pending_d = 1'b1;
        end
      end else begin
        lanes_d = lanes_nxt;
        count_d = cnt_nxt;
        op_d    = beat_op;
      end
    end
`ifdef CAM_PACK_TIMEOUT_EN
    else if (count_q != '0) begin
      if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        idle_d = '0;
        if (out_free) begin
          out_load     = 1'b1;
          out_hdr.last = 1'b0;
          count_d      = '0;
          lanes_d      = '{default: '0};
        end else begin
          last_d    = 1'b0;
          pending_d = 1'b1;
        end
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
`endif
  end

  always_comb begin
    out_word = '0;
    for (int i = 0; i < LANES; i++) out_word[i*ELEM_WIDTH +: ELEM_WIDTH] = word_lanes[i];
    out_word[C_DATA_WIDTH-1 -: HDR_W] = out_hdr;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      lanes_q   <= '{default: '0};
      count_q   <= '0;
      op_q      <= CAM_OP_LOAD;
      last_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      lanes_q   <= lanes_d;
      count_q   <= count_d;
      op_q      <= op_d;
      last_q    <= last_d;
      pending_q <= pending_d;
    end
  end

`ifdef CAM_PACK_TIMEOUT_EN
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) idle_q <= '0;
    else           idle_q <= idle_d;
  end
`endif

  cam_stream_out_reg #(.W(C_DATA_WIDTH)) u_out_reg (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .load_i (out_load),
    .dat_i  (out_word),
    .rdy_i  (p0_TREADY),
    .vld_o  (p0_TVALID),
    .dat_o  (p0_TDATA),
    .free_o (out_free)
  );

endmodule
